// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks: FSM state encoding,
// parity mode selectors and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Bit periods per frame: start + 8 data + optional parity + stop.
    // Unknown parity modes fall back to no parity.
    function automatic int frame_bits(input int parity);
        return (parity == PARITY_EVEN || parity == PARITY_ODD) ? 11 : 10;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period with a one-cycle bit_end pulse.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int           W    = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation matches the synthesised hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_end = enable && (count_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, one
// stop bit. Accepts a byte on tx_start in IDLE and pulses tx_done at frame end.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam bit HAS_PARITY = (frame_bits(PARITY) == 11);
    localparam bit ODD_PARITY = (PARITY == PARITY_ODD);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       baud_clear;
    logic       bit_end;

    // Timer restarts on every state change so each bit gets a full period.
    assign baud_clear = (state_q == ST_IDLE) || (state_d != state_q);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .enable (state_q != ST_IDLE),
        .bit_end(bit_end)
    );

    always_comb begin
        // NOTE: every next-state signal holds its value by default first, so no
        // branch of the case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d   = data_in;
                    parity_d  = (^data_in) ^ ODD_PARITY;
                    bit_idx_d = 3'd0;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        if (HAS_PARITY) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no/even/odd parity) at
// four clocks per bit, checked cycle by cycle against a frame scoreboard.
module tb_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        int         inst;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic [2:0] tx_start_r;
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    int   par_mode [3] = '{0, 1, 2};
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt [3] = '{0, 0, 0};
    exp_t sb[$];
    logic [7:0] io_sb[$];
    bit   io_mon_en = 1'b0;
    int   io_rx_cnt = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_dut0 (
        .clk(clk), .reset(reset), .tx_start(tx_start_r[0]), .data_in(data_in),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_dut1 (
        .clk(clk), .reset(reset), .tx_start(tx_start_r[1]), .data_in(data_in),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_dut2 (
        .clk(clk), .reset(reset), .tx_start(tx_start_r[2]), .data_in(data_in),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) if (done_w[i] === 1'b1) done_cnt[i]++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Serial decoder for the IO integration run: samples mid-bit on instance 0.
    always begin
        logic [7:0] b;
        logic [7:0] e;
        @(negedge clk);
        if (io_mon_en && tx_w[0] === 1'b0) begin
            repeat (2) @(negedge clk);
            n_checks++;
            if (tx_w[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL io_start_bit: tx=%b, required 0", tx_w[0]);
            end
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) @(negedge clk);
                b[j] = tx_w[0];
            end
            repeat (CPB) @(negedge clk);
            n_checks++;
            if (tx_w[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL io_stop_bit: tx=%b, required 1", tx_w[0]);
            end
            n_checks++;
            if (io_sb.size() == 0) begin
                n_fail++;
                $display("FAIL io_byte: got %02h, required nothing (scoreboard empty)", b);
            end else begin
                e = io_sb.pop_front();
                if (b !== e) begin
                    n_fail++;
                    $display("FAIL io_byte: got %02h, required %02h", b, e);
                end
            end
            io_rx_cnt++;
        end
    end

    // Called at a negedge; returns at the cycle-0 sample point of the new frame.
    task automatic send(input int inst, input logic [7:0] d);
        data_in          = d;
        tx_start_r[inst] = 1'b1;
        sb.push_back('{inst, d});
        @(negedge clk);
        tx_start_r[inst] = 1'b0;
        data_in          = ~d;
    endtask

    // Checks every cycle of the frame; returns at the tx_done sample point.
    task automatic check_frame(input int inst, input int inject_at);
        exp_t        e;
        logic [10:0] bits;
        int          nb;
        int          ones;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_scoreboard: empty, required a pending frame");
            return;
        end
        e    = sb.pop_front();
        nb   = (par_mode[inst] != 0) ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            bits[1+i] = e.data[i];
            if (e.data[i]) ones++;
        end
        if (par_mode[inst] == 1) bits[9] = (ones % 2 == 1);
        if (par_mode[inst] == 2) bits[9] = (ones % 2 == 0);
        for (int k = 0; k < nb * CPB; k++) begin
            if (k == inject_at) begin
                tx_start_r[inst] = 1'b1;
                data_in          = 8'h55;
            end
            if (k == inject_at + 1) tx_start_r[inst] = 1'b0;
            n_checks++;
            if (tx_w[inst] !== bits[k/CPB] || busy_w[inst] !== 1'b1 || done_w[inst] !== 1'b0) begin
                n_fail++;
                $display("FAIL frame inst%0d data %02h cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                         inst, e.data, k, tx_w[inst], busy_w[inst], done_w[inst], bits[k/CPB]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (tx_w[inst] !== 1'b1 || busy_w[inst] !== 1'b0 || done_w[inst] !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_end inst%0d at cycle %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=1",
                     inst, nb * CPB, tx_w[inst], busy_w[inst], done_w[inst]);
        end
    endtask

    task automatic check_idle(input int inst, input string name);
        n_checks++;
        if (tx_w[inst] !== 1'b1 || busy_w[inst] !== 1'b0 || done_w[inst] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s inst%0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     name, inst, tx_w[inst], busy_w[inst], done_w[inst]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, "reset_state");
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_idle(i, "post_reset_idle");
        end
    endtask

    task automatic test_basic();
        send(0, 8'hA5);
        check_frame(0, -1);
        @(negedge clk);
        check_idle(0, "basic_after_done");
    endtask

    task automatic test_parity();
        send(1, 8'hA5);
        check_frame(1, -1);
        @(negedge clk);
        send(2, 8'hA5);
        check_frame(2, -1);
        @(negedge clk);
        send(1, 8'h07);
        check_frame(1, -1);
        @(negedge clk);
        check_idle(1, "parity_after_done");
    endtask

    task automatic test_busy_reject();
        int base;
        base = done_cnt[0];
        send(0, 8'hA5);
        check_frame(0, 12);
        repeat (50) begin
            @(negedge clk);
            check_idle(0, "busy_reject_no_second_frame");
        end
        n_checks++;
        if (done_cnt[0] - base !== 1) begin
            n_fail++;
            $display("FAIL busy_reject_done_count: %0d pulses, required 1", done_cnt[0] - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = done_cnt[0];
        send(0, 8'hA5);
        check_frame(0, -1);
        send(0, 8'h00);
        check_frame(0, -1);
        @(negedge clk);
        check_idle(0, "b2b_after_done");
        n_checks++;
        if (done_cnt[0] - base !== 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: %0d pulses, required 2", done_cnt[0] - base);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   base;
        exp_t dropped;
        base = done_cnt[0];
        send(0, 8'hA5);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame_async: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     tx_w[0], busy_w[0], done_w[0]);
        end
        dropped = sb.pop_back();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle(0, "reset_mid_frame_idle");
        end
        n_checks++;
        if (done_cnt[0] !== base) begin
            n_fail++;
            $display("FAIL reset_mid_frame_no_done: %0d pulses, required 0 (aborted %02h)",
                     done_cnt[0] - base, dropped.data);
        end
        send(0, 8'h3C);
        check_frame(0, -1);
        @(negedge clk);
    endtask

    task automatic test_io_integration();
        logic [7:0] ram [8];
        int         base;
        int         t;
        base = done_cnt[0];
        for (int a = 0; a < 8; a++) ram[a] = 8'($urandom_range(0, 255));
        io_mon_en = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            data_in       = ram[a];
            io_sb.push_back(ram[a]);
            tx_start_r[0] = 1'b1;
            @(negedge clk);
            tx_start_r[0] = 1'b0;
            data_in       = 8'hFF;
            t = 0;
            while (done_w[0] !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            n_checks++;
            if (t >= 200) begin
                n_fail++;
                $display("FAIL io_done_timeout addr %0d: no tx_done within 200 cycles", a);
            end
        end
        repeat (10) @(negedge clk);
        io_mon_en = 1'b0;
        n_checks++;
        if (io_rx_cnt !== 8 || io_sb.size() !== 0) begin
            n_fail++;
            $display("FAIL io_byte_count: decoded %0d with %0d pending, required 8 with 0 pending",
                     io_rx_cnt, io_sb.size());
        end
        n_checks++;
        if (done_cnt[0] - base !== 8) begin
            n_fail++;
            $display("FAIL io_done_count: %0d pulses, required 8", done_cnt[0] - base);
        end
    endtask

    initial begin
        reset      = 1'b1;
        tx_start_r = '0;
        data_in    = '0;
        test_reset();
        test_basic();
        test_parity();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid_frame();
        test_io_integration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
